// File: rtl/multi_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : multi_spi_tx
// Purpose  : Nibble-wide transmitter for the 4-lane MultiSPI link. Sends a
//            REGSIZE-bit word MSB nibble first over four data lanes with a
//            strobe clock. A 2-bit select tells the far-end receivers which
//            one captures the word.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   REGSIZE    word width in bits (multiple of 4, >= 8)
//   DIV        clk cycles per beat (even, >= 2)
// Ports
//   clk        in   clock, all logic on posedge
//   rst        in   asynchronous active-high reset
//   load_valid in   a word is offered on load_data/load_sel
//   load_ready out  block can accept a word (high only in IDLE)
//   load_data  in   word to send
//   load_sel   in   target select, 2'b00 reserved as "no target"
//   abort      in   synchronous cancel of the transfer in progress
//   q          out  data lanes, MSB nibble first
//   sclk       out  strobe, receiver samples q on its rising edge
//   s_out      out  select, holds load_sel while frame=1, otherwise 2'b00
//   frame      out  high while beats are being sent
//   done       out  one-cycle pulse when a transfer completes normally
// Configuration
//   MULTI_SPI_TX_PARITY_EN  when defined, one extra beat carrying the XOR of
//                           all data nibbles is appended to every frame.
// ============================================================================
module multi_spi_tx #(
  parameter int REGSIZE = 32,
  parameter int DIV     = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [REGSIZE-1:0] load_data,
  input  logic [1:0]         load_sel,
  input  logic               abort,
  output logic [3:0]         q,
  output logic               sclk,
  output logic [1:0]         s_out,
  output logic               frame,
  output logic               done
);

  localparam int NB = REGSIZE / 4;
`ifdef MULTI_SPI_TX_PARITY_EN
  localparam int NBT = NB + 1;
`else
  localparam int NBT = NB;
`endif
  localparam int CW = $clog2(DIV);
  localparam int BW = $clog2(NBT);

  localparam logic [CW-1:0] C_CYC_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] C_CYC_HALF  = CW'(DIV / 2);
  localparam logic [BW-1:0] C_BEAT_LAST = BW'(NBT - 1);
`ifdef MULTI_SPI_TX_PARITY_EN
  localparam logic [BW-1:0] C_BEAT_PAR  = BW'(NB);
`endif

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t              r_state;
  // Holds the nibbles still to be sent; the first nibble goes straight to q.
  logic [REGSIZE-5:0]  r_shreg;
  logic [CW-1:0]       r_cyc;
  logic [BW-1:0]       r_beat;
  logic [CW-1:0]       w_cyc_nxt;
  logic [BW-1:0]       w_beat_nxt;

  assign w_cyc_nxt  = r_cyc + 1'b1;
  assign w_beat_nxt = r_beat + 1'b1;

`ifdef MULTI_SPI_TX_PARITY_EN
  logic [3:0] r_par;

  function automatic logic [3:0] nib_xor(input logic [REGSIZE-1:0] d);
    logic [3:0] acc;
    acc = 4'h0;
    for (int i = 0; i < NB; i++) begin
      acc = acc ^ d[4*i +: 4];
    end
    return acc;
  endfunction
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_shreg    <= '0;
      r_cyc      <= '0;
      r_beat     <= '0;
      q          <= 4'h0;
      sclk       <= 1'b0;
      s_out      <= 2'b00;
      frame      <= 1'b0;
      done       <= 1'b0;
      load_ready <= 1'b1;
`ifdef MULTI_SPI_TX_PARITY_EN
      r_par      <= 4'h0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          done <= 1'b0;
          // Loads are only possible here, so a simultaneous abort is moot.
          if (load_valid && load_ready) begin
            r_state    <= S_SHIFT;
            load_ready <= 1'b0;
            q          <= load_data[REGSIZE-1 -: 4];
            r_shreg    <= load_data[REGSIZE-5:0];
            s_out      <= load_sel;
            frame      <= 1'b1;
            sclk       <= 1'b0;
            r_cyc      <= '0;
            r_beat     <= '0;
`ifdef MULTI_SPI_TX_PARITY_EN
            r_par      <= nib_xor(load_data);
`endif
          end
        end

        S_SHIFT: begin
          if (abort) begin
            r_state    <= S_IDLE;
            load_ready <= 1'b1;
            q          <= 4'h0;
            sclk       <= 1'b0;
            s_out      <= 2'b00;
            frame      <= 1'b0;
            r_cyc      <= '0;
            r_beat     <= '0;
          end else if (r_cyc == C_CYC_LAST) begin
            // Beat boundary: sclk restarts low and q moves to the next beat.
            r_cyc <= '0;
            sclk  <= 1'b0;
            if (r_beat == C_BEAT_LAST) begin
              r_state <= S_GAP;
              r_beat  <= '0;
              q       <= 4'h0;
              s_out   <= 2'b00;
              frame   <= 1'b0;
              done    <= 1'b1;
            end else begin
              r_beat  <= w_beat_nxt;
              r_shreg <= r_shreg << 4;
`ifdef MULTI_SPI_TX_PARITY_EN
              if (w_beat_nxt == C_BEAT_PAR) begin
                q <= r_par;
              end else begin
                q <= r_shreg[REGSIZE-5 -: 4];
              end
`else
              q <= r_shreg[REGSIZE-5 -: 4];
`endif
            end
          end else begin
            r_cyc <= w_cyc_nxt;
            // Second half of the beat drives the strobe high.
            sclk  <= (w_cyc_nxt >= C_CYC_HALF);
          end
        end

        S_GAP: begin
          done <= 1'b0;
          if (r_cyc == C_CYC_LAST) begin
            r_state    <= S_IDLE;
            load_ready <= 1'b1;
            r_cyc      <= '0;
          end else begin
            r_cyc <= w_cyc_nxt;
          end
        end

        default: begin
          r_state    <= S_IDLE;
          load_ready <= 1'b1;
          q          <= 4'h0;
          sclk       <= 1'b0;
          s_out      <= 2'b00;
          frame      <= 1'b0;
          done       <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_multi_spi_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_multi_spi_tx
// Purpose  : Directed self-checking bench for multi_spi_tx. One instance with
//            REGSIZE=32/DIV=2 covers normal frames, back-to-back loads, abort
//            and mid-frame reset; a second instance with REGSIZE=8/DIV=4 is
//            checked beat by beat and through a loopback receiver model.
//            Expectations follow MULTI_SPI_TX_PARITY_EN when it is defined.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multi_spi_tx;

`ifdef MULTI_SPI_TX_PARITY_EN
  localparam int NBT32 = 9;
  localparam int NBT8  = 3;
`else
  localparam int NBT32 = 8;
  localparam int NBT8  = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;

  logic        lv32 = 1'b0, rdy32, ab32 = 1'b0;
  logic [31:0] ld32 = '0;
  logic [1:0]  ls32 = 2'b00, so32;
  logic [3:0]  q32;
  logic        sclk32, fr32, dn32;

  logic        lv8 = 1'b0, rdy8, ab8 = 1'b0;
  logic [7:0]  ld8 = '0;
  logic [1:0]  ls8 = 2'b00, so8;
  logic [3:0]  q8;
  logic        sclk8, fr8, dn8;

  logic [15:0] rx8 = '0;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  multi_spi_tx #(.REGSIZE(32), .DIV(2)) u_dut32 (
    .clk(clk), .rst(rst), .load_valid(lv32), .load_ready(rdy32),
    .load_data(ld32), .load_sel(ls32), .abort(ab32), .q(q32),
    .sclk(sclk32), .s_out(so32), .frame(fr32), .done(dn32)
  );

  multi_spi_tx #(.REGSIZE(8), .DIV(4)) u_dut8 (
    .clk(clk), .rst(rst), .load_valid(lv8), .load_ready(rdy8),
    .load_data(ld8), .load_sel(ls8), .abort(ab8), .q(q8),
    .sclk(sclk8), .s_out(so8), .frame(fr8), .done(dn8)
  );

  // Loopback receiver: captures a nibble on every rising strobe.
  always @(posedge sclk8) rx8 <= {rx8[11:0], q8};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [3:0] nib32(input logic [31:0] d, input int beat);
    logic [31:0] t;
    logic [3:0]  acc;
    if (beat < 8) begin
      t = d >> (28 - 4 * beat);
      return t[3:0];
    end
    acc = 4'h0;
    for (int i = 0; i < 8; i++) begin
      t = d >> (4 * i);
      acc = acc ^ t[3:0];
    end
    return acc;
  endfunction

  task automatic send32(input logic [31:0] d, input logic [1:0] s);
    @(negedge clk);
    chk("ready_before_load", {31'd0, rdy32}, 32'd1);
    lv32 = 1'b1; ld32 = d; ls32 = s;
    @(posedge clk);
    #1 lv32 = 1'b0;
  endtask

  // Checks a whole DIV=2 frame starting with the cycle after the accepting
  // edge, then the two GAP cycles and the IDLE cycle that follows.
  task automatic check_frame32(input logic [31:0] d, input logic [1:0] s);
    for (int i = 0; i < NBT32 * 2; i++) begin
      @(negedge clk);
      chk("frame_q",     {28'd0, q32},    {28'd0, nib32(d, i / 2)});
      chk("frame_sclk",  {31'd0, sclk32}, (i % 2 == 1) ? 32'd1 : 32'd0);
      chk("frame_high",  {31'd0, fr32},   32'd1);
      chk("frame_sel",   {30'd0, so32},   {30'd0, s});
      chk("frame_nodone",{31'd0, dn32},   32'd0);
      chk("frame_busy",  {31'd0, rdy32},  32'd0);
    end
    @(negedge clk);
    chk("gap1_outs", {q32, sclk32, so32, fr32}, 32'd0);
    chk("gap1_done", {31'd0, dn32},  32'd1);
    chk("gap1_busy", {31'd0, rdy32}, 32'd0);
    @(negedge clk);
    chk("gap2_outs", {q32, sclk32, so32, fr32}, 32'd0);
    chk("gap2_done", {31'd0, dn32},  32'd0);
    chk("gap2_busy", {31'd0, rdy32}, 32'd0);
    @(negedge clk);
    chk("idle_frame", {31'd0, fr32},  32'd0);
    chk("idle_ready", {31'd0, rdy32}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_outs32", {q32, sclk32, so32, fr32, dn32}, 32'd0);
    chk("rst_ready32", {31'd0, rdy32}, 32'd1);
    chk("rst_outs8", {q8, sclk8, so8, fr8, dn8}, 32'd0);
    chk("rst_ready8", {31'd0, rdy8}, 32'd1);
    rst = 1'b0;

    // T1/T2: single word, nibbles 1..8 (plus parity 8 when enabled)
    send32(32'h12345678, 2'b01);
    check_frame32(32'h12345678, 2'b01);

    // T3: load_valid held; second word taken only after GAP + IDLE cycle
    @(negedge clk);
    lv32 = 1'b1; ld32 = 32'hA5A5A5A5; ls32 = 2'b10;
    @(posedge clk);
    #1 ld32 = 32'h0F0F0F0F; ls32 = 2'b11;
    check_frame32(32'hA5A5A5A5, 2'b10);
    @(posedge clk);
    #1 lv32 = 1'b0;
    check_frame32(32'h0F0F0F0F, 2'b11);

    // T4: abort during beat 3
    send32(32'hDEADBEEF, 2'b01);
    repeat (4) @(negedge clk);
    @(negedge clk);
    chk("abort_pre_q", {28'd0, q32}, 32'h0000000A);
    ab32 = 1'b1;
    @(posedge clk);
    #1 ab32 = 1'b0;
    @(negedge clk);
    chk("abort_outs",  {q32, sclk32, so32, fr32, dn32}, 32'd0);
    chk("abort_ready", {31'd0, rdy32}, 32'd1);
    repeat (3) begin
      @(negedge clk);
      chk("abort_nodone", {31'd0, dn32}, 32'd0);
    end
    send32(32'h13572468, 2'b10);
    check_frame32(32'h13572468, 2'b10);

    // T5: asynchronous reset during beat 5
    send32(32'h9ABCDEF0, 2'b11);
    repeat (8) @(negedge clk);
    @(negedge clk);
    chk("rst_pre_q", {28'd0, q32}, 32'h0000000D);
    chk("rst_pre_frame", {31'd0, fr32}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("rst_async_outs", {q32, sclk32, so32, fr32, dn32}, 32'd0);
    chk("rst_async_ready", {31'd0, rdy32}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_nodone", {30'd0, fr32, dn32}, 32'd0);
    end

    // T6: REGSIZE=8, DIV=4, word C3 with loopback capture
    @(negedge clk);
    chk("t6_ready", {31'd0, rdy8}, 32'd1);
    lv8 = 1'b1; ld8 = 8'hC3; ls8 = 2'b01;
    @(posedge clk);
    #1 lv8 = 1'b0;
    for (int i = 0; i < NBT8 * 4; i++) begin
      @(negedge clk);
      chk("t6_q", {28'd0, q8},
          (i / 4 == 0) ? 32'hC : (i / 4 == 1) ? 32'h3 : 32'hF);
      chk("t6_sclk", {31'd0, sclk8}, ((i % 4) >= 2) ? 32'd1 : 32'd0);
      chk("t6_frame", {29'd0, so8, fr8}, 32'd3);
    end
    @(negedge clk);
    chk("t6_gap", {q8, sclk8, so8, fr8}, 32'd0);
    chk("t6_done", {31'd0, dn8}, 32'd1);
`ifdef MULTI_SPI_TX_PARITY_EN
    chk("t6_loopback", {20'd0, rx8[11:0]}, 32'h00000C3F);
`else
    chk("t6_loopback", {24'd0, rx8[7:0]}, 32'h000000C3);
`endif
    repeat (4) @(negedge clk);
    chk("t6_idle", {30'd0, rdy8, dn8}, 32'd2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
